// File: rtl/ram_stack_pkg.sv
// Shared definitions for the RAM-backed hardware stack controller:
// command opcodes and controller FSM states.
package ram_stack_pkg;

    // Command opcodes carried on cmd_op
    typedef enum logic [1:0] {
        OP_NOP     = 2'b00,
        OP_PUSH    = 2'b01,
        OP_POP     = 2'b10,
        OP_REPLACE = 2'b11
    } op_e;

    // Controller states: RUN accepts commands, ERROR blocks them until err_clr
    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_ERROR = 1'b1
    } state_e;

    // Width of the element count; covers 0..DEPTH+1 for DEPTH up to 256
    localparam int COUNT_W = 9;

endpackage

// File: rtl/ram_stack.sv
// LIFO controller in front of a single-port RAM owned by the parent.
// The top-of-stack word lives in a register, so a POP needs only one RAM read and
// a PUSH only one RAM write (spilling the old TOS). Everything below TOS lives in
// RAM at addresses 0..sp-1.
module ram_stack
    import ram_stack_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 256
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    input  logic [1:0]         cmd_op,
    input  logic [WIDTH-1:0]   cmd_data,
    output logic               cmd_ready,
    input  logic               err_clr,
    output logic [WIDTH-1:0]   tos,
    output logic               tos_valid,
    output logic [COUNT_W-1:0] depth,
    output logic               overflow,
    output logic               underflow,
    output logic [WIDTH-1:0]   ram_din,
    output logic [7:0]         ram_addr,
    output logic               ram_we,
    input  logic [WIDTH-1:0]   ram_dout
);

    localparam logic [COUNT_W-1:0] RamEntries = COUNT_W'(DEPTH);

    state_e             state_q, state_d;
    logic [COUNT_W-1:0] sp_q, sp_d;
    logic [WIDTH-1:0]   tos_q, tos_d;
    logic               tosValid_q, tosValid_d;
    logic               overflow_q, overflow_d;
    logic               underflow_q, underflow_d;
    logic               accept;
    logic [7:0]         idleAddr;
    op_e                op;

    assign op        = op_e'(cmd_op);
    assign cmd_ready = (state_q == ST_RUN);
    assign accept    = cmd_valid & cmd_ready;
    assign tos       = tos_q;
    assign tos_valid = tosValid_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
    assign depth     = sp_q + {{(COUNT_W-1){1'b0}}, tosValid_q};

    // The idle address points at the entry just below TOS so a POP can read it without a mux change
    assign idleAddr = (sp_q == '0) ? 8'd0 : 8'(sp_q - 9'd1);

    // State register; reset empties the stack and clears the sticky flags at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            sp_q        <= '0;
            tos_q       <= '0;
            tosValid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sp_q        <= sp_d;
            tos_q       <= tos_d;
            tosValid_q  <= tosValid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Next-state and RAM port decode; an illegal command's flag set wins over a same-cycle clear
    always_comb begin
        state_d     = state_q;
        sp_d        = sp_q;
        tos_d       = tos_q;
        tosValid_d  = tosValid_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        ram_we      = 1'b0;
        ram_addr    = idleAddr;
        ram_din     = tos_q;

        if (err_clr) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
            state_d     = ST_RUN;
        end

        if (accept) begin
            case (op)
                OP_PUSH: begin
                    if (!tosValid_q) begin
                        tos_d      = cmd_data;
                        tosValid_d = 1'b1;
                    end else if (sp_q < RamEntries) begin
                        ram_we   = 1'b1;
                        ram_addr = sp_q[7:0];
                        sp_d     = sp_q + 9'd1;
                        tos_d    = cmd_data;
                    end else begin
                        overflow_d = 1'b1;
                        state_d    = ST_ERROR;
                    end
                end
                OP_POP: begin
                    if (!tosValid_q) begin
                        underflow_d = 1'b1;
                        state_d     = ST_ERROR;
                    end else if (sp_q != '0) begin
                        tos_d = ram_dout;
                        sp_d  = sp_q - 9'd1;
                    end else begin
                        tosValid_d = 1'b0;
                    end
                end
                OP_REPLACE: begin
                    if (!tosValid_q) begin
                        underflow_d = 1'b1;
                        state_d     = ST_ERROR;
                    end else begin
                        tos_d = cmd_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_stack.sv
// Bench for ram_stack: a small DEPTH so full/empty are reached often, a behavioural
// RAM beside the controller, and a queue-based stack model for expectations.
module tb_ram_stack;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam logic [1:0] NOP = 2'b00, PUSH = 2'b01, POP = 2'b10, REPL = 2'b11;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cmd_valid = 1'b0;
    logic [1:0]       cmd_op = 2'b00;
    logic [WIDTH-1:0] cmd_data = '0;
    logic             cmd_ready;
    logic             err_clr = 1'b0;
    logic [WIDTH-1:0] tos;
    logic             tos_valid;
    logic [8:0]       depth;
    logic             overflow;
    logic             underflow;
    logic [WIDTH-1:0] ram_din;
    logic [7:0]       ram_addr;
    logic             ram_we;
    logic [WIDTH-1:0] ram_dout;

    logic [WIDTH-1:0] mem [0:255];

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [WIDTH-1:0] stk[$];
    logic [WIDTH-1:0] mTos = '0;
    logic             mOvf = 1'b0;
    logic             mUnf = 1'b0;
    logic             mErr = 1'b0;
    logic             expWe;
    logic [7:0]       expAddr;
    logic [WIDTH-1:0] expDin;
    logic             weSeen;
    logic [7:0]       addrSeen;
    logic [WIDTH-1:0] dinSeen;

    ram_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
        .err_clr(err_clr),
        .tos(tos), .tos_valid(tos_valid), .depth(depth),
        .overflow(overflow), .underflow(underflow),
        .ram_din(ram_din), .ram_addr(ram_addr), .ram_we(ram_we), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    // Behavioural single-port RAM with combinational read
    assign ram_dout = mem[ram_addr];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
    end

    // Advance the stack model by one command from the pre-edge state
    task automatic modelStep(input logic v, input logic [1:0] op, input logic [WIDTH-1:0] d, input logic clr);
        logic acc;
        acc = v && !mErr;
        expWe = 1'b0;
        expAddr = '0;
        expDin = '0;
        if (clr) begin
            mOvf = 1'b0;
            mUnf = 1'b0;
            mErr = 1'b0;
        end
        if (acc) begin
            case (op)
                PUSH: begin
                    if (stk.size() == DEPTH + 1) begin
                        mOvf = 1'b1;
                        mErr = 1'b1;
                    end else begin
                        if (stk.size() > 0) begin
                            expWe = 1'b1;
                            expAddr = 8'(stk.size() - 1);
                            expDin = stk[stk.size()-1];
                        end
                        stk.push_back(d);
                        mTos = d;
                    end
                end
                POP: begin
                    if (stk.size() == 0) begin
                        mUnf = 1'b1;
                        mErr = 1'b1;
                    end else begin
                        void'(stk.pop_back());
                        if (stk.size() > 0) mTos = stk[stk.size()-1];
                    end
                end
                REPL: begin
                    if (stk.size() == 0) begin
                        mUnf = 1'b1;
                        mErr = 1'b1;
                    end else begin
                        stk[stk.size()-1] = d;
                        mTos = d;
                    end
                end
                default: begin
                end
            endcase
        end
    endtask

    task automatic modelReset();
        stk.delete();
        mTos = '0;
        mOvf = 1'b0;
        mUnf = 1'b0;
        mErr = 1'b0;
    endtask

    // Present one command for one cycle, record the RAM port, then withdraw it
    task automatic applyStimulus(input logic v, input logic [1:0] op, input logic [WIDTH-1:0] d, input logic clr);
        @(negedge clk);
        cmd_valid = v;
        cmd_op = op;
        cmd_data = d;
        err_clr = clr;
        #1;
        weSeen = ram_we;
        addrSeen = ram_addr;
        dinSeen = ram_din;
        modelStep(v, op, d, clr);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        err_clr = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (tos_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_tos_valid got %b want 0", tos_valid); end
        checks++; if (depth !== 9'd0) begin errors++; $display("[TB] FAIL reset_depth got %0d want 0", depth); end
        checks++; if (tos !== 16'h0) begin errors++; $display("[TB] FAIL reset_tos got %h want 0000", tos); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got %b want 1", cmd_ready); end
        checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("[TB] FAIL reset_flags got %b want 00", {overflow, underflow}); end
    endtask

    task automatic test_push3();
        applyStimulus(1, PUSH, 16'h1111, 0);
        checks++; if (weSeen !== 1'b0) begin errors++; $display("[TB] FAIL push_empty_we got %b want 0", weSeen); end
        applyStimulus(1, PUSH, 16'h2222, 0);
        checks++; if (weSeen !== 1'b1 || addrSeen !== 8'd0 || dinSeen !== 16'h1111) begin errors++; $display("[TB] FAIL push2_ram got we=%b addr=%0d din=%h want we=1 addr=0 din=1111", weSeen, addrSeen, dinSeen); end
        applyStimulus(1, PUSH, 16'h3333, 0);
        checks++; if (tos !== 16'h3333) begin errors++; $display("[TB] FAIL push3_tos got %h want 3333", tos); end
        checks++; if (depth !== 9'd3) begin errors++; $display("[TB] FAIL push3_depth got %0d want 3", depth); end
        checks++; if (mem[0] !== 16'h1111 || mem[1] !== 16'h2222) begin errors++; $display("[TB] FAIL push3_ram got %h,%h want 1111,2222", mem[0], mem[1]); end
    endtask

    task automatic test_pop3();
        logic anyWe;
        anyWe = 1'b0;
        applyStimulus(1, POP, 16'h0, 0);
        anyWe |= weSeen;
        checks++; if (tos !== 16'h2222) begin errors++; $display("[TB] FAIL pop1_tos got %h want 2222", tos); end
        applyStimulus(1, POP, 16'h0, 0);
        anyWe |= weSeen;
        checks++; if (tos !== 16'h1111 || depth !== 9'd1) begin errors++; $display("[TB] FAIL pop2 got tos=%h depth=%0d want 1111/1", tos, depth); end
        applyStimulus(1, POP, 16'h0, 0);
        anyWe |= weSeen;
        checks++; if (tos_valid !== 1'b0 || depth !== 9'd0) begin errors++; $display("[TB] FAIL pop3 got valid=%b depth=%0d want 0/0", tos_valid, depth); end
        checks++; if (anyWe !== 1'b0) begin errors++; $display("[TB] FAIL pop_we got %b want 0", anyWe); end
    endtask

    task automatic test_underflow();
        applyStimulus(1, POP, 16'h0, 0);
        checks++; if (underflow !== 1'b1 || cmd_ready !== 1'b0) begin errors++; $display("[TB] FAIL underflow got unf=%b ready=%b want 1/0", underflow, cmd_ready); end
        applyStimulus(1, PUSH, 16'h5555, 0);
        checks++; if (depth !== 9'd0 || tos_valid !== 1'b0) begin errors++; $display("[TB] FAIL error_ignores got depth=%0d valid=%b want 0/0", depth, tos_valid); end
        applyStimulus(1, PUSH, 16'h6666, 1);
        checks++; if (cmd_ready !== 1'b1 || underflow !== 1'b0) begin errors++; $display("[TB] FAIL err_clr got ready=%b unf=%b want 1/0", cmd_ready, underflow); end
        checks++; if (depth !== 9'd0) begin errors++; $display("[TB] FAIL clr_cmd_dropped got depth=%0d want 0", depth); end
        applyStimulus(1, REPL, 16'h7777, 0);
        checks++; if (underflow !== 1'b1 || tos_valid !== 1'b0) begin errors++; $display("[TB] FAIL replace_empty got unf=%b valid=%b want 1/0", underflow, tos_valid); end
        applyStimulus(0, NOP, 16'h0, 1);
        checks++; if (underflow !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL clr2 got unf=%b ready=%b want 0/1", underflow, cmd_ready); end
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= DEPTH + 1; i++) applyStimulus(1, PUSH, 16'(16'h0100 + i), 0);
        checks++; if (depth !== 9'(DEPTH + 1) || tos !== 16'h0105) begin errors++; $display("[TB] FAIL fill got depth=%0d tos=%h want 5/0105", depth, tos); end
        applyStimulus(1, PUSH, 16'h0BAD, 0);
        checks++; if (overflow !== 1'b1 || cmd_ready !== 1'b0) begin errors++; $display("[TB] FAIL overflow got ovf=%b ready=%b want 1/0", overflow, cmd_ready); end
        checks++; if (tos !== 16'h0105 || depth !== 9'd5 || weSeen !== 1'b0) begin errors++; $display("[TB] FAIL overflow_nochange got tos=%h depth=%0d we=%b want 0105/5/0", tos, depth, weSeen); end
        applyStimulus(0, NOP, 16'h0, 1);
        applyStimulus(1, POP, 16'h0, 0);
        checks++; if (tos !== 16'h0104 || overflow !== 1'b0) begin errors++; $display("[TB] FAIL full_pop got tos=%h ovf=%b want 0104/0", tos, overflow); end
        for (int i = 0; i < DEPTH; i++) applyStimulus(1, POP, 16'h0, 0);
        checks++; if (depth !== 9'd0) begin errors++; $display("[TB] FAIL drain got depth=%0d want 0", depth); end
    endtask

    task automatic test_back_to_back();
        applyStimulus(1, PUSH, 16'h000A, 0);
        applyStimulus(1, REPL, 16'h000B, 0);
        checks++; if (tos !== 16'h000B || depth !== 9'd1) begin errors++; $display("[TB] FAIL replace got tos=%h depth=%0d want 000b/1", tos, depth); end
        applyStimulus(1, PUSH, 16'h000C, 0);
        applyStimulus(1, POP, 16'h0, 0);
        checks++; if (tos !== 16'h000B || depth !== 9'd1) begin errors++; $display("[TB] FAIL b2b_pop got tos=%h depth=%0d want 000b/1", tos, depth); end
        applyStimulus(1, POP, 16'h0, 0);
    endtask

    task automatic test_async_reset();
        applyStimulus(1, PUSH, 16'hAAAA, 0);
        applyStimulus(1, PUSH, 16'hBBBB, 0);
        applyStimulus(1, PUSH, 16'hCCCC, 0);
        checks++; if (depth !== 9'd3) begin errors++; $display("[TB] FAIL pre_reset_depth got %0d want 3", depth); end
        #1 rst_n = 1'b0;
        #1;
        modelReset();
        checks++; if (tos_valid !== 1'b0 || depth !== 9'd0 || tos !== 16'h0) begin errors++; $display("[TB] FAIL async_reset got valid=%b depth=%0d tos=%h want 0/0/0000", tos_valid, depth, tos); end
        checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("[TB] FAIL async_reset_flags got %b want 00", {overflow, underflow}); end
        #1 rst_n = 1'b1;
    endtask

    task automatic test_random();
        logic [1:0] op;
        logic v, clr;
        int r;
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 99);
            op = (r < 45) ? PUSH : (r < 80) ? POP : (r < 92) ? REPL : NOP;
            v = ($urandom_range(0, 9) != 0);
            clr = mErr ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
            applyStimulus(v, op, 16'($urandom), clr);
            checks++; if (weSeen !== expWe) begin errors++; $display("[TB] FAIL rnd_we n=%0d got %b want %b", n, weSeen, expWe); end
            if (expWe) begin
                checks++; if (addrSeen !== expAddr || dinSeen !== expDin) begin errors++; $display("[TB] FAIL rnd_ram n=%0d got %0d/%h want %0d/%h", n, addrSeen, dinSeen, expAddr, expDin); end
            end
            checks++; if (depth !== 9'(stk.size()) || tos_valid !== (stk.size() != 0)) begin errors++; $display("[TB] FAIL rnd_depth n=%0d got %0d/%b want %0d", n, depth, tos_valid, stk.size()); end
            checks++; if (tos !== mTos) begin errors++; $display("[TB] FAIL rnd_tos n=%0d got %h want %h", n, tos, mTos); end
            checks++; if (overflow !== mOvf || underflow !== mUnf || cmd_ready !== !mErr) begin errors++; $display("[TB] FAIL rnd_flags n=%0d got ovf=%b unf=%b rdy=%b want %b/%b/%b", n, overflow, underflow, cmd_ready, mOvf, mUnf, !mErr); end
        end
    endtask

    initial begin
        #12 rst_n = 1'b1;
        #1;
        test_reset();
        test_push3();
        test_pop3();
        test_underflow();
        test_overflow();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
